// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and the xtime helper.
// Used by the round sequencer and its round-constant generator.
package aes_pkg;

   localparam int AES_BLOCO          = 128;
   localparam int NUM_RODADAS_AES128 = 10;

   localparam logic [7:0] RCON_INICIAL = 8'h01;

   typedef enum logic [1:0] {
      S_OCIOSO    = 2'd0,
      S_RODADA    = 2'd1,
      S_CONCLUIDO = 2'd2
   } estado_fsm_t;

   // Multiply by x in GF(2^8) modulo the AES polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] r);
      return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/gerador_rcon.sv
// Round-constant register: loads 01 at block start and advances by
// xtime once per round.
module gerador_rcon
   import aes_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       carrega_i,
   input  logic       avanca_i,
   output logic [7:0] rcon_o
);

   logic [7:0] rcon_q, rcon_d;

   // Load has priority; otherwise advance or hold.
   always_comb begin
      rcon_d = rcon_q;
      if (carrega_i)
         rcon_d = RCON_INICIAL;
      else if (avanca_i)
         rcon_d = xtime(rcon_q);
   end

   // Round-constant register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rcon_q <= RCON_INICIAL;
      else
         rcon_q <= rcon_d;
   end

   assign rcon_o = rcon_q;

endmodule

// File: rtl/controle_rodadas.sv
// Iterative AES-128 round sequencer: initial AddRoundKey in-house,
// then one external combinational round per cycle.
module controle_rodadas
   import aes_pkg::*;
#(
   parameter int NUM_RODADAS = NUM_RODADAS_AES128
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         ent_valido,
   output logic         ent_pronto,
   input  logic [127:0] ent_texto,
   input  logic [127:0] ent_chave,
   output logic         sai_valido,
   input  logic         sai_pronto,
   output logic [127:0] sai_texto,
   output logic [127:0] dp_estado,
   output logic [127:0] dp_chave,
   output logic [7:0]   dp_rcon,
   output logic         dp_ultima,
   input  logic [127:0] dp_resultado,
   input  logic [127:0] dp_chave_nova,
   output logic [3:0]   rodada
);

   localparam logic [1:0] OCIOSO    = S_OCIOSO;
   localparam logic [1:0] RODADA    = S_RODADA;
   localparam logic [1:0] CONCLUIDO = S_CONCLUIDO;

   localparam logic [3:0] ULTIMA = 4'(NUM_RODADAS);

   logic [1:0]           fsm_q, fsm_d;
   logic [AES_BLOCO-1:0] estado_q, estado_d;
   logic [AES_BLOCO-1:0] chave_q, chave_d;
   logic [3:0]           rodada_q, rodada_d;
   logic                 carrega, avanca;

   // Next-state logic: accept, iterate rounds, hold result.
   always_comb begin
      fsm_d    = fsm_q;
      estado_d = estado_q;
      chave_d  = chave_q;
      rodada_d = rodada_q;
      carrega  = 1'b0;
      avanca   = 1'b0;
      case (fsm_q)
         OCIOSO: begin
            if (ent_valido) begin
               estado_d = ent_texto ^ ent_chave;
               chave_d  = ent_chave;
               rodada_d = 4'd1;
               carrega  = 1'b1;
               fsm_d    = RODADA;
            end
         end
         RODADA: begin
            estado_d = dp_resultado;
            chave_d  = dp_chave_nova;
            avanca   = 1'b1;
            if (rodada_q == ULTIMA)
               fsm_d = CONCLUIDO;
            else
               rodada_d = rodada_q + 4'd1;
         end
         CONCLUIDO: begin
            if (sai_pronto) begin
               fsm_d    = OCIOSO;
               rodada_d = 4'd0;
            end
         end
         default: fsm_d = OCIOSO;
      endcase
   end

   // State, key, round-counter and FSM registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q    <= OCIOSO;
         estado_q <= '0;
         chave_q  <= '0;
         rodada_q <= 4'd0;
      end else begin
         fsm_q    <= fsm_d;
         estado_q <= estado_d;
         chave_q  <= chave_d;
         rodada_q <= rodada_d;
      end
   end

   gerador_rcon u_rcon (
      .clk       (clk),
      .rst       (rst),
      .carrega_i (carrega),
      .avanca_i  (avanca),
      .rcon_o    (dp_rcon)
   );

   assign ent_pronto = (fsm_q == OCIOSO);
   assign sai_valido = (fsm_q == CONCLUIDO);
   assign sai_texto  = estado_q;
   assign dp_estado  = estado_q;
   assign dp_chave   = chave_q;
   assign dp_ultima  = (fsm_q == RODADA) && (rodada_q == ULTIMA);
   assign rodada     = rodada_q;

endmodule

// File: tb/tb_controle_rodadas.sv
// Directed bench for controle_rodadas with a behavioural AES round
// model standing in for the external datapath.
module tb_controle_rodadas;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // DUT A: full AES-128 (10 rounds)
   logic         a_ev, a_ep, a_sv, a_sp, a_ult;
   logic [127:0] a_et, a_ek, a_st, a_de, a_dk, a_res, a_nova;
   logic [7:0]   a_rc;
   logic [3:0]   a_rd;

   // DUT B: single round
   logic         b_ev, b_ep, b_sv, b_sp, b_ult;
   logic [127:0] b_et, b_ek, b_st, b_de, b_dk, b_res, b_nova;
   logic [7:0]   b_rc;
   logic [3:0]   b_rd;

   controle_rodadas #(.NUM_RODADAS(10)) dut_a (
      .clk(clk), .rst(rst),
      .ent_valido(a_ev), .ent_pronto(a_ep),
      .ent_texto(a_et), .ent_chave(a_ek),
      .sai_valido(a_sv), .sai_pronto(a_sp), .sai_texto(a_st),
      .dp_estado(a_de), .dp_chave(a_dk), .dp_rcon(a_rc),
      .dp_ultima(a_ult), .dp_resultado(a_res),
      .dp_chave_nova(a_nova), .rodada(a_rd)
   );

   controle_rodadas #(.NUM_RODADAS(1)) dut_b (
      .clk(clk), .rst(rst),
      .ent_valido(b_ev), .ent_pronto(b_ep),
      .ent_texto(b_et), .ent_chave(b_ek),
      .sai_valido(b_sv), .sai_pronto(b_sp), .sai_texto(b_st),
      .dp_estado(b_de), .dp_chave(b_dk), .dp_rcon(b_rc),
      .dp_ultima(b_ult), .dp_resultado(b_res),
      .dp_chave_nova(b_nova), .rodada(b_rd)
   );

   localparam logic [127:0] PT_A = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] K_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_A = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] R0_A = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K_C  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_X = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

   int n_chk = 0;
   int n_err = 0;

   task automatic checa(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- AES round model ----------------
   logic [7:0] sbox [256];

   function automatic logic [7:0] xt(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] x,
                                       input logic [7:0] y);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = x; bb = y;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = xt(aa);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      logic [15:0] d;
      d = {v, v} << n;
      return d[15:8];
   endfunction

   initial begin
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv, s;
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
             ^ rotl(inv, 4) ^ 8'h63;
         sbox[x] = s;
      end
   end

   function automatic logic [127:0] key_step(input logic [127:0] k,
                                             input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, t;
      w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
      t = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]],
           sbox[w3[31:24]]} ^ {rc, 24'h0};
      w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [127:0] aes_round(input logic [127:0] s,
                                              input logic [127:0] k,
                                              input logic ult);
      logic [7:0] a [16];
      logic [7:0] b [16];
      logic [7:0] c0, c1, c2, c3;
      logic [127:0] r;
      for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
      for (int c = 0; c < 4; c++)
         for (int w = 0; w < 4; w++)
            b[w+4*c] = sbox[a[w+4*((c+w)%4)]];
      if (!ult) begin
         for (int c = 0; c < 4; c++) begin
            c0 = b[4*c]; c1 = b[4*c+1]; c2 = b[4*c+2]; c3 = b[4*c+3];
            b[4*c]   = xt(c0) ^ xt(c1) ^ c1 ^ c2 ^ c3;
            b[4*c+1] = c0 ^ xt(c1) ^ xt(c2) ^ c2 ^ c3;
            b[4*c+2] = c0 ^ c1 ^ xt(c2) ^ xt(c3) ^ c3;
            b[4*c+3] = xt(c0) ^ c0 ^ c1 ^ c2 ^ xt(c3);
         end
      end
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
      return r ^ k;
   endfunction

   // Datapath stand-in, settled mid-cycle ahead of each rising edge.
   always @(negedge clk) begin
      a_nova = key_step(a_dk, a_rc);
      a_res  = aes_round(a_de, a_nova, a_ult);
      b_nova = key_step(b_dk, b_rc);
      b_res  = aes_round(b_de, b_nova, b_ult);
   end

   task automatic passo();
      @(posedge clk);
      #1;
   endtask

   task automatic checa_reset(input string tag);
      checa({tag, "_ent_pronto"}, 128'(a_ep), 128'd1);
      checa({tag, "_sai_valido"}, 128'(a_sv), 128'd0);
      checa({tag, "_sai_texto"}, a_st, 128'd0);
      checa({tag, "_dp_estado"}, a_de, 128'd0);
      checa({tag, "_dp_chave"}, a_dk, 128'd0);
      checa({tag, "_dp_rcon"}, 128'(a_rc), 128'h01);
      checa({tag, "_dp_ultima"}, 128'(a_ult), 128'd0);
      checa({tag, "_rodada"}, 128'(a_rd), 128'd0);
   endtask

   logic [7:0] rcon_esp [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   initial begin
      int acc_t [2];
      logic [127:0] cap [2];
      int nacc, ncap;
      rst = 1'b1;
      a_ev = 0; a_sp = 0; a_et = '0; a_ek = '0;
      b_ev = 0; b_sp = 0; b_et = '0; b_ek = '0;
      repeat (2) @(posedge clk);
      #1;
      checa_reset("reset");
      rst = 1'b0;
      passo();

      // FIPS-197 App. B
      a_et = PT_A; a_ek = K_A; a_ev = 1'b1;
      passo();
      a_ev = 1'b0;
      checa("edge0_estado", a_de, R0_A);
      checa("edge0_chave", a_dk, K_A);
      checa("edge0_rodada", 128'(a_rd), 128'd1);
      for (int i = 1; i <= 10; i++) begin
         checa($sformatf("rcon_r%0d", i), 128'(a_rc), 128'(rcon_esp[i-1]));
         checa($sformatf("ultima_r%0d", i), 128'(a_ult), 128'(i == 10));
         checa($sformatf("sv_low_r%0d", i), 128'(a_sv), 128'd0);
         passo();
      end
      checa("fips_sai_valido", 128'(a_sv), 128'd1);
      checa("fips_sai_texto", a_st, CT_A);

      // Backpressure with a rejected second request
      for (int i = 0; i < 7; i++) begin
         checa("bp_sai_valido", 128'(a_sv), 128'd1);
         checa("bp_sai_texto", a_st, CT_A);
         checa("bp_ent_pronto", 128'(a_ep), 128'd0);
         if (i == 3) begin a_et = PT_X; a_ev = 1'b1; end
         passo();
         a_ev = 1'b0;
      end
      checa("bp_end_valido", 128'(a_sv), 128'd1);
      a_sp = 1'b1;
      passo();
      a_sp = 1'b0;
      checa("bp_release_ent_pronto", 128'(a_ep), 128'd1);
      checa("bp_release_sai_valido", 128'(a_sv), 128'd0);
      checa("bp_no_accept_estado", a_de, CT_A);
      checa("bp_release_rodada", 128'(a_rd), 128'd0);

      // Back-to-back with both handshakes held high
      a_sp = 1'b1; a_et = PT_A; a_ek = K_A; a_ev = 1'b1;
      nacc = 0; ncap = 0; acc_t[0] = 0; acc_t[1] = 0;
      cap[0] = '0; cap[1] = '0;
      for (int c = 0; c < 60 && ncap < 2; c++) begin
         logic aceito;
         aceito = a_ep && a_ev;
         if (aceito) begin acc_t[nacc] = c; nacc++; end
         if (a_sv && a_sp) begin cap[ncap] = a_st; ncap++; end
         passo();
         if (aceito && nacc == 1) begin a_et = PT_C; a_ek = K_C; end
         if (aceito && nacc == 2) a_ev = 1'b0;
      end
      a_ev = 1'b0; a_sp = 1'b0;
      checa("b2b_accepts", 128'(nacc), 128'd2);
      checa("b2b_outputs", 128'(ncap), 128'd2);
      checa("b2b_spacing", 128'(acc_t[1] - acc_t[0]), 128'd12);
      checa("b2b_ct1", cap[0], CT_A);
      checa("b2b_ct2", cap[1], CT_C);
      passo();

      // Reset during round 5, then a fresh block
      a_et = PT_A; a_ek = K_A; a_ev = 1'b1;
      passo();
      a_ev = 1'b0;
      repeat (4) passo();
      checa("mid_rodada5", 128'(a_rd), 128'd5);
      checa("mid_rcon5", 128'(a_rc), 128'h10);
      rst = 1'b1;
      #2;
      checa_reset("mid_async");
      passo();
      checa_reset("mid_next");
      rst = 1'b0;
      passo();
      a_et = PT_C; a_ek = K_C; a_ev = 1'b1;
      passo();
      a_ev = 1'b0;
      repeat (9) passo();
      checa("fresh_not_yet", 128'(a_sv), 128'd0);
      passo();
      checa("fresh_sai_valido", 128'(a_sv), 128'd1);
      checa("fresh_sai_texto", a_st, CT_C);

      // Single-round instance
      b_et = PT_A; b_ek = K_A; b_ev = 1'b1;
      passo();
      b_ev = 1'b0;
      checa("nr1_ultima", 128'(b_ult), 128'd1);
      checa("nr1_rcon", 128'(b_rc), 128'h01);
      checa("nr1_sv_low", 128'(b_sv), 128'd0);
      passo();
      checa("nr1_sai_valido", 128'(b_sv), 128'd1);
      checa("nr1_ultima_off", 128'(b_ult), 128'd0);
      checa("nr1_sai_texto", b_st,
            aes_round(PT_A ^ K_A, key_step(K_A, 8'h01), 1'b1));

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/controle_rodadas.md
# controle_rodadas

Iterative AES-128 encryption round sequencer. It accepts one plaintext/key pair over a valid/ready handshake and performs the initial AddRoundKey itself. It then drives one shared external combinational round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey plus one key-schedule step) once per cycle for NUM_RODADAS cycles, and presents the ciphertext on a valid/ready output. It sits between the host bus adapter and the existing combinational AES round blocks.

## Interface
- NUM_RODADAS, default 10: number of full rounds; the last round skips MixColumns. Legal range is 1..14.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- ent_valido  in  1  input block valid.
- ent_pronto  out  1  controller can accept a block.
- ent_texto  in  128  plaintext, byte 0 in [127:120].
- ent_chave  in  128  cipher key, same byte order.
- sai_valido  out  1  ciphertext valid.
- sai_pronto  in  1  consumer accepts the ciphertext.
- sai_texto  out  128  ciphertext; it is the state register.
- dp_estado  out  128  state fed to the datapath; it is the state register.
- dp_chave  out  128  previous round key fed to the key-schedule step.
- dp_rcon  out  8  round constant for the current round.
- dp_ultima  out  1  high while the current round is the final round; the datapath bypasses MixColumns.
- dp_resultado  in  128  combinational round output, computed with dp_chave_nova as the AddRoundKey key.
- dp_chave_nova  in  128  combinational next round key, computed from dp_chave and dp_rcon.
- rodada  out  4  current round index, for debug.

## Operation
- FSM states: OCIOSO, RODADA, CONCLUIDO. Reset state is OCIOSO.
- OCIOSO:
  - ent_pronto=1.
  - On ent_valido&&ent_pronto: estado<=ent_texto^ent_chave; chave<=ent_chave; rcon<=8'h01; rodada<=1; go to RODADA.
- RODADA:
  - Every cycle: estado<=dp_resultado; chave<=dp_chave_nova; rcon<=xtime(rcon).
  - If rodada==NUM_RODADAS, go to CONCLUIDO; otherwise rodada<=rodada+1.
- xtime(r) = {r[6:0],1'b0} ^ (r[7] ? 8'h1b : 8'h00). Sequence: 01,02,04,08,10,20,40,80,1b,36,6c,d8,ab,4d.
- dp_ultima = (state==RODADA) && (rodada==NUM_RODADAS).
- CONCLUIDO:
  - sai_valido=1; sai_texto is held stable.
  - On sai_pronto: go to OCIOSO. rodada<=0.
- ent_pronto is 0 outside OCIOSO; ent_valido there is ignored and not queued.
- sai_pronto outside CONCLUIDO is ignored.
- Reset at any point, including mid-round or while sai_valido is held, aborts the block. All registers clear; no partial output is ever presented.

## Timing
- Reset values: ent_pronto=1, sai_valido=0, sai_texto=dp_estado=0, dp_chave=0, dp_rcon=8'h01, dp_ultima=0, rodada=0.
- Latency, with the accept edge as edge 0:
  - Round i (1..NUM_RODADAS) is computed during the cycle after edge i-1.
  - sai_valido rises after edge NUM_RODADAS, i.e. 10 cycles after accept for AES-128.
- Throughput: at most one block per NUM_RODADAS+2 cycles with sai_pronto tied high. The output handshake cycle and the next accept never overlap.
- sai_valido, once high, stays high with sai_texto unchanged until sai_pronto is sampled high.
- The datapath path dp_estado/dp_chave -> dp_resultado/dp_chave_nova must close in one cycle; the controller adds only a 2:1 mux ahead of the registers.

## Structure
- Shared package aes_pkg holds:
  - AES_BLOCO=128
  - NUM_RODADAS_AES128=10
  - RCON_INICIAL=8'h01
  - the xtime function
  - the FSM state enum type
- One natural sub-module, gerador_rcon: an 8-bit register with load-to-01 and advance-by-xtime controls.
- The datapath stays outside this block.

## Test plan
- FIPS-197 App. B: ent_texto=3243f6a8885a308d313198a2e0370734, ent_chave=2b7e151628aed2a6abf7158809cf4f3c, golden round model attached.
  - After edge 0: dp_estado=193de3bea0f4e22b9ac68d2ae9f84808.
  - After 10 more edges: sai_valido=1, sai_texto=3925841d02dc09fbdc118597196a0b32.
- Rcon and last-round flag: log dp_rcon in rounds 1..10 -> 01,02,04,08,10,20,40,80,1b,36; dp_ultima high only in round 10.
- Backpressure: hold sai_pronto=0 for 7 cycles.
  - sai_valido and sai_texto stay stable; ent_pronto=0 throughout.
  - A second ent_valido pulse is not accepted.
- Back-to-back: two blocks with sai_pronto=1 and ent_valido=1 continuously -> the second accept occurs exactly 12 cycles after the first; both ciphertexts are correct.
- Mid-operation reset: assert rst during round 5 -> on the next cycle all outputs are at reset values and the FSM is OCIOSO; a fresh block afterwards yields the correct ciphertext.
- NUM_RODADAS=1: sai_valido 1 cycle after accept; dp_ultima high in that round; output equals golden model of one final round.
